// File: rtl/cpu_writeback_pkg.sv
// cpu_writeback_pkg
//   Shared encodings for the writeback stage: branch condition codes,
//   stack push-source selects, writeback FSM states and a helper that
//   resolves whether a branch is taken.
package cpu_writeback_pkg;

   localparam int          STACK_W       = 35;
   localparam int          POP_W         = 11;
   localparam logic [31:0] RET_PC_OFFSET = 32'd6;   // length of a call instruction

   typedef enum logic [1:0] {
      BR_NONE     = 2'd0,
      BR_UNCOND   = 2'd1,
      BR_IF_TRUE  = 2'd2,
      BR_IF_FALSE = 2'd3
   } branch_e;

   // Codes 6 and 7 are unused and mean "no push".
   typedef enum logic [2:0] {
      PUSH_NONE   = 3'd0,
      PUSH_ALU    = 3'd1,
      PUSH_R0     = 3'd2,
      PUSH_R1     = 3'd3,
      PUSH_MEM    = 3'd4,
      PUSH_RET_PC = 3'd5
   } push_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_KILL     = 2'd2
   } wb_state_e;

   function automatic logic branch_taken(input logic [1:0] br, input logic cond);
      logic taken;
      case (branch_e'(br))
         BR_UNCOND:   taken = 1'b1;
         BR_IF_TRUE:  taken = cond;
         BR_IF_FALSE: taken = ~cond;
         default:     taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/wb_push_mux.sv
// wb_push_mux
//   Combinational selector for the value pushed onto the stack.
//   push_sel   : push-source code from execute
//   alu_out    : ALU result (zero-extended when pushed)
//   r0, r1     : full-width stack operands
//   pc         : instruction address; the return address is pc+6 (wraps)
//   mem_rdata  : load data (only meaningful when the load completes)
//   push_valid : a push is requested by this code
//   push_data  : value to push, zero when push_valid is low
module wb_push_mux
   import cpu_writeback_pkg::*;
(
   input  logic [2:0]         push_sel,
   input  logic [31:0]        alu_out,
   input  logic [STACK_W-1:0] r0,
   input  logic [STACK_W-1:0] r1,
   input  logic [31:0]        pc,
   input  logic [31:0]        mem_rdata,
   output logic               push_valid,
   output logic [STACK_W-1:0] push_data
);

   logic [31:0] ret_pc;

   // 32-bit add, so the return address wraps modulo 2^32.
   assign ret_pc = pc + RET_PC_OFFSET;

   always_comb begin
      push_valid = 1'b0;
      push_data  = '0;
      case (push_sel_e'(push_sel))
         PUSH_ALU:    begin push_valid = 1'b1; push_data = {3'b000, alu_out};   end
         PUSH_R0:     begin push_valid = 1'b1; push_data = r0;                  end
         PUSH_R1:     begin push_valid = 1'b1; push_data = r1;                  end
         PUSH_MEM:    begin push_valid = 1'b1; push_data = {3'b000, mem_rdata}; end
         PUSH_RET_PC: begin push_valid = 1'b1; push_data = {3'b000, ret_pc};    end
         default:     ;
      endcase
   end

endmodule

// File: rtl/cpu_writeback.sv
// cpu_writeback
//   Stage-4 writeback: turns registered execute results into a stack
//   pop/push command, performs data-memory loads, and issues branch
//   redirects followed by a kill window that squashes younger instructions.
//   clk, rst_b            : clock; synchronous active-high reset
//   *_3a inputs           : execute results, held stable while stall_4a=1
//   mem__req/addr/ack/rdata : load handshake
//   st__pop_4a, st__push_* : stack command (pop applied before push)
//   kill_4a, redirect_*   : branch redirect and squash window
//   stall_4a              : upstream must hold during a load
//   mem_fault_4a          : one-cycle pulse when a load is abandoned
module cpu_writeback
   import cpu_writeback_pkg::*;
#(
   parameter int KILL_CYCLES = 3,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                alu__cond_3a,
   input  logic [31:0]         alu__out_3a,
   input  logic [1:0]          c__branch_3a,
   input  logic [2:0]          c__to_push_3a,
   input  logic [POP_W-1:0]    st__to_pop_3a,
   input  logic [31:0]         pc_3a,
   input  logic [47:0]         instruction_3a,
   input  logic [STACK_W-1:0]  r0_3a,
   input  logic [STACK_W-1:0]  r1_3a,
   output logic                mem__req,
   output logic [31:0]         mem__addr,
   input  logic                mem__ack,
   input  logic [31:0]         mem__rdata,
   output logic [POP_W-1:0]    st__pop_4a,
   output logic                st__push_valid_4a,
   output logic [STACK_W-1:0]  st__push_data_4a,
   output logic                kill_4a,
   output logic                redirect_valid_4a,
   output logic [31:0]         redirect_pc_4a,
   output logic                stall_4a,
   output logic                mem_fault_4a
);

   localparam int KILL_W = $clog2(KILL_CYCLES + 1);
   localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);

   wb_state_e           state_reg;
   logic [KILL_W-1:0]   kill_cnt_reg;
   logic [TO_W-1:0]     wait_cnt_reg;
   logic [31:0]         mem_addr_reg;

   logic                mux_valid;
   logic [STACK_W-1:0]  mux_data;
   logic                taken;
   logic                load_start;
   logic                in_wait;
   logic                unused_instr_hi;

   assign unused_instr_hi = ^instruction_3a[47:32];

   wb_push_mux u_push_mux (
      .push_sel   (c__to_push_3a),
      .alu_out    (alu__out_3a),
      .r0         (r0_3a),
      .r1         (r1_3a),
      .pc         (pc_3a),
      .mem_rdata  (mem__rdata),
      .push_valid (mux_valid),
      .push_data  (mux_data)
   );

   assign taken = branch_taken(c__branch_3a, alu__cond_3a);

   // The request goes out combinationally in the accepting cycle so the
   // memory sees it without an extra bubble; reset masks it immediately.
   assign load_start = !rst_b && (state_reg == ST_IDLE) && (c__to_push_3a == PUSH_MEM);
   assign in_wait    = !rst_b && (state_reg == ST_MEM_WAIT);
   assign mem__req   = load_start | in_wait;
   assign mem__addr  = in_wait ? mem_addr_reg : (load_start ? alu__out_3a : 32'd0);
   assign stall_4a   = mem__req;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_reg         <= ST_IDLE;
         kill_cnt_reg      <= '0;
         wait_cnt_reg      <= '0;
         mem_addr_reg      <= '0;
         st__pop_4a        <= '0;
         st__push_valid_4a <= 1'b0;
         st__push_data_4a  <= '0;
         kill_4a           <= 1'b0;
         redirect_valid_4a <= 1'b0;
         redirect_pc_4a    <= '0;
         mem_fault_4a      <= 1'b0;
      end else begin
         // Command outputs are single-cycle pulses.
         st__pop_4a        <= '0;
         st__push_valid_4a <= 1'b0;
         st__push_data_4a  <= '0;
         redirect_valid_4a <= 1'b0;
         redirect_pc_4a    <= '0;
         mem_fault_4a      <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (c__to_push_3a == PUSH_MEM) begin
                  // Pop, push and branch of a load are deferred to the ack.
                  state_reg    <= ST_MEM_WAIT;
                  mem_addr_reg <= alu__out_3a;
                  wait_cnt_reg <= '0;
               end else begin
                  st__pop_4a        <= st__to_pop_3a;
                  st__push_valid_4a <= mux_valid;
                  st__push_data_4a  <= mux_data;
                  if (taken) begin
                     redirect_valid_4a <= 1'b1;
                     redirect_pc_4a    <= instruction_3a[31:0];
                     kill_4a           <= 1'b1;
                     kill_cnt_reg      <= KILL_W'(KILL_CYCLES);
                     state_reg         <= ST_KILL;
                  end
               end
            end

            ST_MEM_WAIT: begin
               if (mem__ack) begin
                  // Inputs are still held, so the mux selects the load data.
                  st__pop_4a        <= st__to_pop_3a;
                  st__push_valid_4a <= mux_valid;
                  st__push_data_4a  <= mux_data;
                  wait_cnt_reg      <= '0;
                  mem_addr_reg      <= '0;
                  if (taken) begin
                     redirect_valid_4a <= 1'b1;
                     redirect_pc_4a    <= instruction_3a[31:0];
                     kill_4a           <= 1'b1;
                     kill_cnt_reg      <= KILL_W'(KILL_CYCLES);
                     state_reg         <= ST_KILL;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else if (wait_cnt_reg == TO_W'(MEM_TIMEOUT - 1)) begin
                  // Abandon the whole instruction: no pop, push or branch.
                  mem_fault_4a <= 1'b1;
                  wait_cnt_reg <= '0;
                  mem_addr_reg <= '0;
                  state_reg    <= ST_IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
               end
            end

            ST_KILL: begin
               if (kill_cnt_reg <= KILL_W'(1)) begin
                  kill_4a      <= 1'b0;
                  kill_cnt_reg <= '0;
                  state_reg    <= ST_IDLE;
               end else begin
                  kill_cnt_reg <= kill_cnt_reg - KILL_W'(1);
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cpu_writeback.md
CPU_WRITEBACK -- requirements
Module: cpu_writeback

Interface
REQ-001 SHALL have parameter KILL_CYCLES, default 3: number of cycles kill_4a is held after a redirect.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before the load is abandoned.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_b  in  1  reset; synchronous, active-high (already decided).
REQ-005 SHALL have ports alu__cond_3a in 1, alu__out_3a in 32, c__branch_3a in 2, c__to_push_3a in 3, st__to_pop_3a in 11, pc_3a in 32, instruction_3a in 48, r0_3a in 35, r1_3a in 35: registered stage-3 results from execute.
REQ-006 SHALL have ports mem__req out 1, mem__addr out 32, mem__ack in 1, mem__rdata in 32: data-memory load handshake.
REQ-007 SHALL have ports st__pop_4a out 11, st__push_valid_4a out 1, st__push_data_4a out 35: stack update command.
REQ-008 SHALL have ports kill_4a out 1, redirect_valid_4a out 1, redirect_pc_4a out 32, stall_4a out 1, mem_fault_4a out 1.

Function
REQ-009 SHALL decode c__branch_3a: 0 none; 1 unconditional; 2 taken when alu__cond_3a=1; 3 taken when alu__cond_3a=0.
REQ-010 SHALL, on a taken branch, register redirect_valid_4a=1 for one cycle with redirect_pc_4a=instruction_3a[31:0].
REQ-011 SHALL assert kill_4a for exactly KILL_CYCLES cycles starting the cycle after the taken branch is accepted.
REQ-012 SHALL ignore 3a inputs (no push, pop, redirect, or mem request) during any cycle kill_4a=1.
REQ-013 SHALL restart the kill count at KILL_CYCLES if a new taken branch is accepted in the same cycle the last kill cycle ends.
REQ-014 SHALL decode c__to_push_3a: 0 none; 1 {3'b0,alu__out_3a}; 2 r0_3a; 3 r1_3a; 4 memory load; 5 {3'b0,pc_3a+32'd6}; 6-7 none.
REQ-015 SHALL register st__pop_4a=st__to_pop_3a and the push command one cycle after acceptance (latency 1).
REQ-016 SHALL implement FSM states IDLE, MEM_WAIT, KILL.
REQ-017 IDLE->MEM_WAIT when c__to_push_3a=4 and not killed: mem__req=1, mem__addr=alu__out_3a, stall_4a=1 combinationally that cycle.
REQ-018 SHALL hold mem__req, mem__addr, and stall_4a stable in MEM_WAIT until mem__ack=1.
REQ-019 On mem__ack, SHALL drop mem__req next cycle, push {3'b0,mem__rdata} with st__pop_4a, and then evaluate the branch of the same instruction.
REQ-020 SHALL ignore mem__ack outside MEM_WAIT.
REQ-021 SHALL, on MEM_TIMEOUT cycles without ack, abandon the load: no push, mem_fault_4a=1 for one cycle, return to IDLE.
REQ-022 Upstream holds 3a inputs stable while stall_4a=1; block SHALL NOT re-sample them mid-wait.
REQ-023 IDLE/MEM_WAIT->KILL on taken branch; KILL->IDLE after KILL_CYCLES cycles.
REQ-024 Pop and push in the same instruction SHALL be emitted in the same cycle; stack applies pop before push.
REQ-025 pc_3a+6 SHALL wrap modulo 2^32.

Reset
REQ-026 With rst_b=1 at a clock edge, all outputs SHALL be 0, the FSM SHALL be IDLE, and the kill and timeout counters SHALL be 0.
REQ-027 Reset during MEM_WAIT SHALL drop mem__req on the next cycle and discard any pending push.

Structure
REQ-028 Branch codes, push-select codes, and FSM state encodings SHALL be defined in shared opcode.vh alongside the existing UC_* constants.
REQ-029 SHALL use one sub-module, wb_push_mux, as the combinational push-data selector; the FSM and counters stay in cpu_writeback.

Verification
REQ-030 c__branch_3a=1, instruction_3a[31:0]=0x100 -> next cycle redirect_valid_4a=1 and redirect_pc_4a=0x100; kill_4a high for exactly 3 cycles; a push presented during those cycles produces no push.
REQ-031 c__branch_3a=2 with alu__cond_3a=0 -> no redirect and no kill; c__branch_3a=3 with alu__cond_3a=0 -> redirect.
REQ-032 c__to_push_3a=4, alu__out_3a=0x40, mem__ack after 5 cycles with rdata 0xDEADBEEF -> mem__req/stall_4a high for 6 cycles, then push 0x0DEADBEEF.
REQ-033 Load with no ack for 255 cycles -> mem_fault_4a pulses once, no push, state returns to IDLE.
REQ-034 c__to_push_3a=5, pc_3a=0xFFFFFFFC -> pushed data 0x000000002 (wrap).
REQ-035 rst_b asserted on the 3rd MEM_WAIT cycle -> next cycle mem__req=0, no push, all outputs 0.
